// File: rtl/seq_divider_8bit_if.sv
// Request/response bundle for the sequential divider.
// Handshake: the controller raises start with dividend/divisor valid; the
// request is taken on a rising edge only while the divider is in IDLE or
// DONE (busy=0). busy is high while iterating, and start is ignored then.
// done is a one-cycle strobe marking new quotient/remainder/result/div_by_zero.
interface seq_divider_8bit_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [2*WIDTH-1:0] result;
    logic               div_by_zero;

    // Controller side: issues requests and observes results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, result, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, result, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8bit.sv
// Unsigned restoring divider, one quotient bit per clock.
// The result is packed as {remainder, quotient} to match the ALU result word.
// A zero divisor skips iteration and reports quotient=all ones,
// remainder=dividend, div_by_zero=1.
module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_divider_8bit_if.slave     bus,
    output logic [1:0]            dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   pr_q, pr_d;       // partial remainder, one guard bit
    logic [WIDTH-1:0] wq_q, wq_d;       // working quotient / shifting dividend
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor captured at acceptance
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_neg;
    logic [WIDTH:0]   pr_next;
    logic [WIDTH-1:0] wq_next;

    // Next-state, datapath step and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        wq_d    = wq_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        // One restoring step: shift {pr, wq} left, try subtracting divisor.
        shifted   = {pr_q[WIDTH-1:0], wq_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};
        trial_neg = trial[WIDTH];
        pr_next   = trial_neg ? shifted : trial;
        wq_next   = {wq_q[WIDTH-2:0], ~trial_neg};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        wq_d    = bus.dividend;
                        pr_d    = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        dvs_d   = bus.divisor;
                        state_d = CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                pr_d  = pr_next;
                wq_d  = wq_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    quo_d   = wq_next;
                    rem_d   = pr_next[WIDTH-1:0];
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            wq_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            wq_q    <= wq_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy        = (state_q == CALC);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.result      = {rem_q, quo_q};
    assign bus.div_by_zero = dz_q;
    assign dbg_state       = state_q;
endmodule
